// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-port arbiter state encoding and requester ids.
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-port, D-port and unified-memory signals around the arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();

  // instruction fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  // load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch
// (I) and load/store (D) ports. D has priority, but I is granted once D has
// won STARVE_MAX consecutive grants while I was waiting.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_TOP  = STV_W'(STARVE_MAX);

  arb_state_t        state;
  arb_state_t        next_state;

  logic              grant_i;
  logic              grant_d;
  logic              done;

  logic              req_id;
  logic              lat_we;
  logic [ADDR_W-3:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  lat_cnt;
  logic [STV_W-1:0]  starve_cnt;

  logic              i_gnt_r;
  logic              d_gnt_r;
  logic              i_rvalid_r;
  logic              d_rvalid_r;
  logic [DATA_W-1:0] i_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;

  // Byte-offset bits never reach the word-addressed memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= next_state;
  end

  // Next-state, arbitration decision and memory strobes.
  always_comb begin
    next_state    = state;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    done          = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      ARB_IDLE: begin
        if (bus.d_req && !(bus.i_req && starve_cnt == STV_TOP)) grant_d = 1'b1;
        else if (bus.i_req)                                     grant_i = 1'b1;
        if (grant_i || grant_d) next_state = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = lat_we;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        next_state    = lat_we ? ARB_IDLE : ARB_WAIT;
      end
      ARB_WAIT: begin
        if (lat_cnt == '0) begin
          done       = 1'b1;
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Grant pulses, payload latch, latency countdown and read-data return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_gnt_r    <= 1'b0;
      d_gnt_r    <= 1'b0;
      i_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      i_rdata_r  <= '0;
      d_rdata_r  <= '0;
      req_id     <= REQ_I;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_cnt    <= '0;
    end else begin
      i_gnt_r    <= grant_i;
      d_gnt_r    <= grant_d;
      i_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      if (grant_d) begin
        req_id    <= REQ_D;
        lat_we    <= bus.d_we;
        lat_addr  <= bus.d_addr[ADDR_W-1:2];
        lat_wdata <= bus.d_wdata;
      end else if (grant_i) begin
        req_id    <= REQ_I;
        lat_we    <= 1'b0;
        lat_addr  <= bus.i_addr[ADDR_W-1:2];
        lat_wdata <= '0;
      end
      if (state == ARB_ISSUE) begin
        if (lat_we) d_rvalid_r <= 1'b1;
        else        lat_cnt    <= LAT_LOAD;
      end else if (state == ARB_WAIT && !done) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (done) begin
        if (req_id == REQ_D) begin
          d_rvalid_r <= 1'b1;
          d_rdata_r  <= bus.mem_rdata;
        end else begin
          i_rvalid_r <= 1'b1;
          i_rdata_r  <= bus.mem_rdata;
        end
      end
    end
  end

  // Consecutive D grants taken while I is waiting, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               starve_cnt <= '0;
    else if (!bus.i_req || grant_i)          starve_cnt <= '0;
    else if (grant_d && starve_cnt != STV_TOP) starve_cnt <= starve_cnt + 1'b1;
  end

  assign bus.i_gnt    = i_gnt_r;
  assign bus.d_gnt    = d_gnt_r;
  assign bus.i_rvalid = i_rvalid_r;
  assign bus.d_rvalid = d_rvalid_r;
  assign bus.i_rdata  = i_rdata_r;
  assign bus.d_rdata  = d_rdata_r;
  assign bus.busy     = (state != ARB_IDLE);

endmodule
